i2c_slave_regs: RTL and testbench

Synthesizable I2C slave (responder) with a small byte-wide register file, the bus-side counterpart of `i2c_master_top`. It decodes START/STOP, matches a fixed 7-bit device address and accepts a memory-address byte. It then services writes and reads with pointer auto-increment, and NACKs out-of-range memory addresses. A local port lets system logic read the register file and observe write events.

---
 rtl/i2c_slave_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C slave with a byte-wide register file, pointer auto-increment and a local read port.
// Optional SCL/SDA glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h10,
  parameter int         AW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic [3:0]    dbg_state
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_MADDR,
    S_WDATA,
    S_DATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic          rw_bit;
  logic [7:0]    regs [DEPTH];

  // Synchronizers and edge-detect history track the pins even during reset,
  // so no phantom edge appears when reset is released mid-transfer.
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_lvl;
  logic       sda_lvl;
  logic       scl_prev;
  logic       sda_prev;

  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[0], scl_i};
    sda_sync <= {sda_sync[0], sda_i};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_filt_q;
  logic       sda_filt_q;

  // Level follows the synchronizer only once three consecutive samples agree.
  assign scl_lvl = (scl_sync[1] == scl_hist[0] && scl_sync[1] == scl_hist[1]) ? scl_sync[1] : scl_filt_q;
  assign sda_lvl = (sda_sync[1] == sda_hist[0] && sda_sync[1] == sda_hist[1]) ? sda_sync[1] : sda_filt_q;

  always_ff @(posedge clk) begin
    scl_hist   <= {scl_hist[0], scl_sync[1]};
    sda_hist   <= {sda_hist[0], sda_sync[1]};
    scl_filt_q <= scl_lvl;
    sda_filt_q <= sda_lvl;
  end
`else
  assign scl_lvl = scl_sync[1];
  assign sda_lvl = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    scl_prev <= scl_lvl;
    sda_prev <= sda_lvl;
  end

  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] rx_byte;
  logic       maddr_ok;

  assign scl_rise   = scl_lvl & ~scl_prev;
  assign scl_fall   = ~scl_lvl & scl_prev;
  assign start_cond = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
  assign stop_cond  = scl_lvl & scl_prev & ~sda_prev & sda_lvl;
  assign rx_byte    = {shreg[6:0], sda_lvl};
  assign maddr_ok   = (rx_byte[7:AW] == '0);
  assign dbg_state  = state;

  // Valid/ready: the bus has no back-pressure; wr_valid is a single-cycle
  // strobe with wr_addr/wr_data valid in the same cycle, and the local read
  // port is always ready with rd_data one cycle after rd_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      ptr      <= '0;
      rw_bit   <= 1'b0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
      rd_data  <= 8'h00;
      busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      rd_data  <= regs[rd_addr];
      if (stop_cond) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_cond) begin
        state   <= S_ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rw_bit <= sda_lvl;
                state  <= (rx_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
              end
            end
          end
          // bit_cnt == 8: waiting to assert ACK; bit_cnt == 9: ACK clock seen.
          S_ADDR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b1;
              end else if (bit_cnt == 4'd9) begin
                bit_cnt <= 4'd0;
                if (rw_bit) begin
                  shreg  <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                  state  <= S_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= S_MADDR;
                end
              end
            end
          end
          S_MADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (maddr_ok) begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= S_DATA_ACK;
                end else begin
                  state <= S_IGNORE;
                end
              end
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                regs[ptr] <= rx_byte;
                wr_valid  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 1'b1;
                state     <= S_DATA_ACK;
              end
            end
          end
          S_DATA_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b1;
              end else if (bit_cnt == 4'd9) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_WDATA;
              end
            end
          end
          // Bit 7 is already on the bus at entry; each fall presents the next bit.
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_RDATA_ACK;
              end else if (bit_cnt != 4'd0) begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_lvl) begin
                ptr     <= ptr + 1'b1;
                bit_cnt <= 4'd9;
              end else begin
                state <= S_IGNORE;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              shreg   <= regs[ptr];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= 4'd0;
              state   <= S_RDATA;
            end
          end
          S_IGNORE: sda_oe <= 1'b0;
          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, transaction-level register model, wr_valid scoreboard.
module tb_i2c_slave_regs;

  localparam int         AW    = 2;
  localparam int         DEPTH = 4;
  localparam logic [6:0] SADDR = 7'h10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_oe;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          busy;
  logic [3:0]    dbg_state;
  logic          sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(SADDR), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    m_mem [DEPTH];
  int            m_ptr;
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] got_q[$];
  logic          oe_seen;

  always @(negedge clk) begin
    if (!rst && wr_valid) got_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic send_bit(input logic b);
    wait_clk(6); sda_m = b;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(12); scl_m = 1'b0;
  endtask

  task automatic send_bit_glitch(input logic b);
    wait_clk(6); sda_m = b;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(5); scl_m = 1'b0;
    wait_clk(2); scl_m = 1'b1;
    wait_clk(5); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(6); sda_m = 1'b1;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(6); b = sda_bus;
    wait_clk(6); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(6); sda_m = 1'b0;
    wait_clk(6); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(6); sda_m = 1'b1;
    wait_clk(12);
  endtask

  // Returns the level seen on the 9th clock: 0 = ACK, 1 = NACK.
  task automatic write_byte(input logic [7:0] b, output logic nb);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(nb);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      b[i] = x;
    end
    send_bit(nack);
  endtask

  task automatic xfer_write(input string tag, input logic [7:0] maddr, input int n,
                            input logic [7:0] d [4], input logic do_stop);
    logic nb;
    logic ok;
    i2c_start();
    write_byte({SADDR, 1'b0}, nb);
    n_checks++;
    if (nb !== 1'b0) begin n_fail++; $display("FAIL %s dev_ack: got %b want 0", tag, nb); end
    ok = (maddr < DEPTH);
    write_byte(maddr, nb);
    n_checks++;
    if (nb !== !ok) begin n_fail++; $display("FAIL %s maddr_ack: got %b want %b", tag, nb, !ok); end
    if (ok) m_ptr = int'(maddr);
    for (int k = 0; k < n; k++) begin
      write_byte(d[k], nb);
      n_checks++;
      if (nb !== !ok) begin n_fail++; $display("FAIL %s data%0d_ack: got %b want %b", tag, k, nb, !ok); end
      if (ok) begin
        m_mem[m_ptr] = d[k];
        exp_q.push_back({m_ptr[AW-1:0], d[k]});
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic xfer_read(input string tag, input int n);
    logic       nb;
    logic [7:0] b;
    i2c_start();
    write_byte({SADDR, 1'b1}, nb);
    n_checks++;
    if (nb !== 1'b0) begin n_fail++; $display("FAIL %s rd_dev_ack: got %b want 0", tag, nb); end
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      n_checks++;
      if (b !== m_mem[m_ptr]) begin
        n_fail++; $display("FAIL %s rd_byte%0d: got %h want %h", tag, k, b, m_mem[m_ptr]);
      end
      if (k != n - 1) m_ptr = (m_ptr + 1) % DEPTH;
    end
    wait_clk(8);
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL %s release_after_nack: got %b want 0", tag, sda_oe); end
    i2c_stop();
  endtask

  task automatic scoreboard_drain(input string tag);
    logic [AW+7:0] e;
    logic [AW+7:0] g;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s wr_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL %s wr_event: got %h want %h", tag, g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_local_port(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      wait_clk(2);
      n_checks++;
      if (rd_data !== m_mem[a]) begin
        n_fail++; $display("FAIL %s rd_data[%0d]: got %h want %h", tag, a, rd_data, m_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(6);
    rst = 1'b0;
    model_reset();
    wait_clk(1);
    n_checks++;
    if ({sda_oe, wr_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got oe/valid/busy %b want 000", {sda_oe, wr_valid, busy});
    end
    n_checks++;
    if ({wr_addr, wr_data, rd_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", wr_addr, wr_data, rd_data);
    end
    test_local_port("reset");
  endtask

  task automatic test_write();
    logic [7:0] d [4];
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    xfer_write("write", 8'h01, 2, d, 1'b1);
    scoreboard_drain("write");
    test_local_port("write");
  endtask

  task automatic test_combined_read();
    logic [7:0] d [4];
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    xfer_write("comb", 8'h01, 0, d, 1'b0);
    xfer_read("comb", 4);
    scoreboard_drain("comb");
  endtask

  task automatic test_invalid_maddr();
    logic [7:0] d [4];
    d = '{8'hFF, 8'h00, 8'h00, 8'h00};
    xfer_write("bad_maddr", 8'h10, 1, d, 1'b1);
    scoreboard_drain("bad_maddr");
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_maddr busy_after_stop: got %b want 0", busy); end
    test_local_port("bad_maddr");
  endtask

  task automatic test_addr_mismatch();
    logic nb;
    i2c_start();
    oe_seen = 1'b0;
    write_byte({7'h11, 1'b0}, nb);
    n_checks++;
    if (nb !== 1'b1) begin n_fail++; $display("FAIL mismatch dev_ack: got %b want 1", nb); end
    for (int k = 0; k < 2; k++) begin
      write_byte(8'($urandom_range(0, 255)), nb);
      n_checks++;
      if (nb !== 1'b1) begin n_fail++; $display("FAIL mismatch data%0d_ack: got %b want 1", k, nb); end
    end
    n_checks++;
    if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL mismatch sda_oe_seen: got %b want 0", oe_seen); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mismatch busy_mid: got %b want 1", busy); end
    i2c_stop();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch busy_after_stop: got %b want 0", busy); end
    scoreboard_drain("mismatch");
  endtask

  task automatic test_reset_during_ack();
    logic       found;
    logic [7:0] d [4];
    found = 1'b0;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 5);
    for (int c = 0; c < 30 && !found; c++) begin
      wait_clk(1);
      if (sda_oe) found = 1'b1;
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rst_ack ack_seen: got %b want 1", found); end
    rst = 1'b1;
    wait_clk(1);
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_ack oe_after_rst: got %b want 0", sda_oe); end
    wait_clk(3);
    rst = 1'b0;
    model_reset();
    i2c_stop();
    test_local_port("rst_ack");
    d[0] = 8'($urandom_range(0, 255));
    d[1] = 8'($urandom_range(0, 255));
    d[2] = 8'h00;
    d[3] = 8'h00;
    xfer_write("rst_ack_wr", 8'h02, 2, d, 1'b1);
    scoreboard_drain("rst_ack_wr");
    test_local_port("rst_ack_wr");
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [7:0] maddr;
    int         n;
    for (int it = 0; it < 6; it++) begin
      maddr = 8'($urandom_range(0, 5));
      n     = int'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
      xfer_write("rand_wr", maddr, n, d, 1'b1);
      xfer_read("rand_rd", int'($urandom_range(1, 4)));
      scoreboard_drain("rand");
    end
    test_local_port("rand");
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic       nb;
    logic [7:0] b;
    b = 8'h3C;
    i2c_start();
    write_byte({SADDR, 1'b0}, nb);
    write_byte(8'h00, nb);
    m_ptr = 0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) send_bit_glitch(b[i]);
      else        send_bit(b[i]);
    end
    recv_bit(nb);
    n_checks++;
    if (nb !== 1'b0) begin n_fail++; $display("FAIL glitch data_ack: got %b want 0", nb); end
    m_mem[0] = b;
    exp_q.push_back({2'd0, b});
    m_ptr = 1;
    i2c_stop();
    scoreboard_drain("glitch");
    test_local_port("glitch");
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_combined_read();
    test_invalid_maddr();
    test_addr_mismatch();
    test_reset_during_ack();
    test_random();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
